// File: rtl/track_filter.sv
`default_nettype none
// ============================================================================
// track_filter : sync, debounce, junction pulse and line-lost timeout for the
//                three IR line-tracker sensors feeding the car-control FSM.
// Revision     : 1.0
// ============================================================================
module track_filter #(
    parameter int STABLE_CYCLES = 50000,
    parameter int JUNC_CYCLES   = 200000,
    parameter int LOST_CYCLES   = 5000000,
    parameter int INVERT        = 0,
    parameter int CW            = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       left_track,
    input  logic       mid_track,
    input  logic       right_track,
    output logic [2:0] detect_road,
    output logic       detect_valid,
    output logic       road_change,
    output logic       junction_pulse,
    output logic       lost,
    output logic [7:0] glitch_cnt
);

    localparam logic [2:0]    C_INV_MASK  = (INVERT != 0) ? 3'b111 : 3'b000;
    localparam logic [CW-1:0] C_STAB_MAX  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] C_JUNC_MAX  = CW'(JUNC_CYCLES - 1);
    localparam logic [CW-1:0] C_LOST_MAX  = CW'(LOST_CYCLES);
    localparam logic [CW-1:0] C_LOST_PRE  = CW'(LOST_CYCLES - 1);

    typedef enum logic [1:0] {
        J_IDLE = 2'd0,
        J_ARM  = 2'd1,
        J_HELD = 2'd2
    } jstate_t;

    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_cand;
    logic [CW-1:0] r_stab;
    logic [2:0]    r_road;
    logic          r_valid;
    logic          r_road_change;
    logic [7:0]    r_glitch;
    jstate_t       r_jstate;
    logic [CW-1:0] r_jcnt;
    logic          r_junc_pulse;
    logic [CW-1:0] r_lcnt;
    logic          r_lost;

    logic [2:0]    w_s;
    logic          w_accept;

    assign w_s      = r_sync2 ^ C_INV_MASK;
    assign w_accept = (w_s == r_cand) && (r_stab == C_STAB_MAX) &&
                      (!r_valid || (r_cand != r_road));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= {left_track, mid_track, right_track};
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand        <= 3'b000;
            r_stab        <= '0;
            r_road        <= 3'b000;
            r_valid       <= 1'b0;
            r_road_change <= 1'b0;
            r_glitch      <= 8'd0;
        end else begin
            r_road_change <= 1'b0;
            if (w_s != r_cand) begin
                r_cand <= w_s;
                r_stab <= '0;
                // A candidate abandoned before it matched the accepted road is a glitch.
                if ((r_cand != r_road) && (r_glitch != 8'hFF)) begin
                    r_glitch <= r_glitch + 8'd1;
                end
            end else if (r_stab == C_STAB_MAX) begin
                if (w_accept) begin
                    r_road        <= r_cand;
                    r_valid       <= 1'b1;
                    r_road_change <= 1'b1;
                end
            end else begin
                r_stab <= r_stab + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_jstate     <= J_IDLE;
            r_jcnt       <= '0;
            r_junc_pulse <= 1'b0;
        end else begin
            r_junc_pulse <= 1'b0;
            case (r_jstate)
                J_IDLE: begin
                    if ((r_road == 3'b111) && r_valid) begin
                        r_jstate <= J_ARM;
                        r_jcnt   <= {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                J_ARM: begin
                    if (r_road != 3'b111) begin
                        r_jstate <= J_IDLE;
                        r_jcnt   <= '0;
                    end else if (r_jcnt >= C_JUNC_MAX) begin
                        r_jstate     <= J_HELD;
                        r_junc_pulse <= 1'b1;
                    end else begin
                        r_jcnt <= r_jcnt + 1'b1;
                    end
                end
                J_HELD: begin
                    if (r_road != 3'b111) begin
                        r_jstate <= J_IDLE;
                        r_jcnt   <= '0;
                    end
                end
                default: begin
                    r_jstate <= J_IDLE;
                    r_jcnt   <= '0;
                end
            endcase
        end
    end

    // Cleared by the load event itself so lost drops on the same edge as the new road.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lcnt <= '0;
            r_lost <= 1'b0;
        end else if (w_accept && (r_cand != 3'b000)) begin
            r_lcnt <= '0;
            r_lost <= 1'b0;
        end else if (r_valid && (r_road == 3'b000) && (r_lcnt != C_LOST_MAX)) begin
            r_lcnt <= r_lcnt + 1'b1;
            if (r_lcnt == C_LOST_PRE) begin
                r_lost <= 1'b1;
            end
        end
    end

    assign detect_road    = r_road;
    assign detect_valid   = r_valid;
    assign road_change    = r_road_change;
    assign junction_pulse = r_junc_pulse;
    assign lost           = r_lost;
    assign glitch_cnt     = r_glitch;

endmodule
`default_nettype wire
